// File: rtl/sbox_pkg.sv
// Shared definitions for the merged forward/inverse S-box datapath.
// Direction encoding matches the ZF input of the top linear layer.
package sbox_pkg;

   localparam logic SBOX_FWD        = 1'b0;
   localparam logic SBOX_INV        = 1'b1;
   localparam int   AES_STATE_BYTES = 16;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } feeder_state_t;

endpackage

// File: rtl/sbox_byte_feeder.sv
// Serialises a block into NBYTES U/ZF beats for the S-box top layer; first beat 1 cycle after accept.
// Beats hold under out_ready=0; a new block can be taken on the final beat with no bubble.
module sbox_byte_feeder
   import sbox_pkg::*;
#(
   parameter int NBYTES    = AES_STATE_BYTES,
   parameter int LSB_FIRST = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [8*NBYTES-1:0]       in_state,
   input  logic                      in_zf,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                out_u,
   output logic                      out_zf,
   output logic [$clog2(NBYTES)-1:0] out_idx,
   output logic                      out_last
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

   feeder_state_t state_q, state_d;
   logic [W-1:0]  buf_q, buf_d;
   logic          zf_q, zf_d;
   logic [IW-1:0] idx_q, idx_d;

   logic is_send;
   logic is_last;
   logic accept;
   logic beat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
         zf_q    <= SBOX_FWD;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         zf_q    <= zf_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      zf_d    = zf_q;
      idx_d   = idx_q;

      is_send = (state_q == SEND);
      is_last = is_send && (idx_q == IDX_LAST);
      // Gated by rst too, so upstream never sees a handshake that reset will drop.
      in_ready = !rst && !flush && (!is_send || (is_last && out_ready));
      accept   = in_valid && in_ready;
      beat     = is_send && out_ready;

      if (flush) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (accept) begin
         state_d = SEND;
         buf_d   = in_state;
         zf_d    = in_zf;
         idx_d   = '0;
      end else if (beat) begin
         if (is_last) begin
            state_d = IDLE;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + 1'b1;
            buf_d = (LSB_FIRST != 0) ? (buf_q >> 8) : (buf_q << 8);
         end
      end
   end

   // The buffer shifts each beat, so the current byte always sits at a fixed end.
   assign out_valid = is_send;
   assign out_u     = (LSB_FIRST != 0) ? buf_q[7:0] : buf_q[W-1 -: 8];
   assign out_zf    = zf_q;
   assign out_idx   = idx_q;
   assign out_last  = is_last;

endmodule

// File: tb/tb_sbox_byte_feeder.sv
// Bench for sbox_byte_feeder: LSB-first and MSB-first instances share stimulus,
// each compared every cycle against a queue-of-expected-beats model.
module tb_sbox_byte_feeder;
   import sbox_pkg::*;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_zf, flush, out_ready;
   logic [127:0] in_state;

   logic       in_ready_a, out_valid_a, out_zf_a, out_last_a;
   logic [7:0] out_u_a;
   logic [3:0] out_idx_a;
   logic       in_ready_b, out_valid_b, out_zf_b, out_last_b;
   logic [7:0] out_u_b;
   logic [3:0] out_idx_b;

   always #5 clk = ~clk;

   sbox_byte_feeder #(.NBYTES(16), .LSB_FIRST(1)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_state(in_state), .in_zf(in_zf), .flush(flush),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_u(out_u_a),
      .out_zf(out_zf_a), .out_idx(out_idx_a), .out_last(out_last_a)
   );

   sbox_byte_feeder #(.NBYTES(16), .LSB_FIRST(0)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_state(in_state), .in_zf(in_zf), .flush(flush),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_u(out_u_b),
      .out_zf(out_zf_b), .out_idx(out_idx_b), .out_last(out_last_b)
   );

   typedef struct packed {
      logic [7:0] u;
      logic       zf;
      logic [3:0] idx;
      logic       last;
   } beat_t;

   beat_t qa[$];
   beat_t qb[$];

   int n_tests = 0;
   int n_fail  = 0;

   // {valid, ready, u, zf, idx, last}; beat fields zeroed when no beat is expected
   logic [15:0] obs_a, obs_b, exp_a, exp_b;
   logic        exp_acc;

   function automatic logic [127:0] ramp(input logic [7:0] base);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = base + 8'(k);
      return r;
   endfunction

   // One clock: sample DUTs and model expectations, advance the model, cross the edge.
   task automatic tick();
      logic  exp_v, exp_r, beat;
      beat_t bt;
      #1;
      exp_v = (qa.size() != 0);
      exp_r = !rst && !flush && (qa.size() == 0 || (qa.size() == 1 && out_ready));
      exp_a = {exp_v, exp_r, 14'b0};
      exp_b = {exp_v, exp_r, 14'b0};
      if (exp_v) begin
         exp_a[13:0] = qa[0];
         exp_b[13:0] = qb[0];
      end
      obs_a = {out_valid_a, in_ready_a, 14'b0};
      obs_b = {out_valid_b, in_ready_b, 14'b0};
      if (exp_v) begin
         obs_a[13:0] = {out_u_a, out_zf_a, out_idx_a, out_last_a};
         obs_b[13:0] = {out_u_b, out_zf_b, out_idx_b, out_last_b};
      end
      exp_acc = in_valid && exp_r;
      beat    = exp_v && out_ready;
      if (rst || flush) begin
         qa.delete();
         qb.delete();
      end else begin
         if (beat) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
         end
         if (exp_acc) begin
            for (int k = 0; k < 16; k++) begin
               bt.zf = in_zf; bt.idx = 4'(k); bt.last = (k == 15);
               bt.u = in_state[8*k +: 8];
               qa.push_back(bt);
               bt.u = in_state[8*(15-k) +: 8];
               qb.push_back(bt);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_zf = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_state = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_tests++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid got a=%b b=%b want 0", out_valid_a, out_valid_b);
      end
      n_tests++;
      if (out_u_a !== 8'h00 || out_u_b !== 8'h00) begin
         n_fail++; $display("FAIL reset_u got a=%h b=%h want 00", out_u_a, out_u_b);
      end
      n_tests++;
      if (out_zf_a !== 1'b0 || out_zf_b !== 1'b0) begin
         n_fail++; $display("FAIL reset_zf got a=%b b=%b want 0", out_zf_a, out_zf_b);
      end
      n_tests++;
      if (out_idx_a !== 4'd0 || out_idx_b !== 4'd0) begin
         n_fail++; $display("FAIL reset_idx got a=%0d b=%0d want 0", out_idx_a, out_idx_b);
      end
      n_tests++;
      if (out_last_a !== 1'b0 || out_last_b !== 1'b0) begin
         n_fail++; $display("FAIL reset_last got a=%b b=%b want 0", out_last_a, out_last_b);
      end
      n_tests++;
      if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got a=%b b=%b want 1", in_ready_a, in_ready_b);
      end
   endtask

   task automatic test_stream(input logic zf, input string name);
      int nvalid = 0;
      in_valid = 1'b1; in_state = ramp(8'h00); in_zf = zf; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (exp_acc) in_valid = 1'b0;
         nvalid += int'(obs_a[15]);
         n_tests++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got a=%h b=%h want a=%h b=%h", name, c, obs_a, obs_b, exp_a, exp_b);
         end
      end
      n_tests++;
      if (nvalid !== 16) begin
         n_fail++; $display("FAIL %s_count got %0d valid beats want 16", name, nvalid);
      end
   endtask

   task automatic test_backpressure();
      int  nvalid = 0;
      int  stall  = 0;
      bit  done   = 0;
      in_valid = 1'b1; in_state = ramp(8'h20); in_zf = SBOX_FWD;
      for (int c = 0; c < 25; c++) begin
         if (!done && qa.size() != 0 && qa[0].idx == 4'd5) begin
            stall = 3; done = 1;
         end
         out_ready = (stall == 0);
         if (stall > 0) stall--;
         tick();
         if (exp_acc) in_valid = 1'b0;
         nvalid += int'(obs_a[15]);
         n_tests++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            n_fail++;
            $display("FAIL backpressure cyc=%0d got a=%h b=%h want a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
         end
      end
      out_ready = 1'b1;
      n_tests++;
      if (nvalid !== 19) begin
         n_fail++; $display("FAIL backpressure_count got %0d valid beats want 19", nvalid);
      end
   endtask

   task automatic test_back_to_back();
      int         nacc = 0, run = 0, best = 0;
      logic [7:0] zf_first_u = 8'hxx;
      bit         seen = 0;
      in_valid = 1'b1; in_state = ramp(8'h00); in_zf = SBOX_FWD; out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (exp_acc) begin
            nacc++;
            if (nacc == 1) begin
               in_state = ramp(8'h10); in_zf = SBOX_INV;
            end else in_valid = 1'b0;
         end
         run  = obs_a[15] ? run + 1 : 0;
         best = (run > best) ? run : best;
         if (!seen && out_valid_a && out_zf_a) begin
            seen = 1; zf_first_u = out_u_a;
         end
         n_tests++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            n_fail++;
            $display("FAIL back_to_back cyc=%0d got a=%h b=%h want a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
         end
      end
      n_tests++;
      if (best !== 32) begin
         n_fail++; $display("FAIL b2b_run got %0d consecutive beats want 32", best);
      end
      n_tests++;
      if (zf_first_u !== 8'h10) begin
         n_fail++; $display("FAIL b2b_zf_switch got first zf=1 byte %h want 10", zf_first_u);
      end
   endtask

   task automatic test_zf_toggle();
      in_valid = 1'b1; in_state = ramp(8'h40); in_zf = SBOX_FWD; out_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         tick();
         if (exp_acc) in_valid = 1'b0;
         in_zf = ~in_zf;
         n_tests++;
         if (obs_a !== exp_a || obs_b !== exp_b || (out_valid_a && out_zf_a !== SBOX_FWD)) begin
            n_fail++;
            $display("FAIL zf_toggle cyc=%0d got a=%h b=%h want a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
         end
      end
      in_zf = SBOX_FWD;
   endtask

   task automatic test_flush();
      int phase = 0;
      in_valid = 1'b1; in_state = ramp(8'h60); in_zf = SBOX_FWD; out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (phase == 1 && qa.size() != 0 && qa[0].idx == 4'd7) begin
            flush = 1'b1; in_valid = 1'b1; in_state = ramp(8'h80); in_zf = SBOX_INV;
            phase = 2;
         end
         tick();
         n_tests++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            n_fail++;
            $display("FAIL flush cyc=%0d got a=%h b=%h want a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
         end
         if (phase == 2) begin
            flush = 1'b0;
            n_tests++;
            if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
               n_fail++; $display("FAIL flush_valid got a=%b b=%b want 0", out_valid_a, out_valid_b);
            end
            phase = 3;
         end else if (exp_acc && (phase == 0 || phase == 3)) begin
            in_valid = 1'b0;
            phase++;
         end
      end
   endtask

   task automatic test_rst_mid();
      in_valid = 1'b1; in_state = ramp(8'ha0); in_zf = SBOX_INV; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (qa.size() != 0 && qa[0].idx == 4'd9) rst = 1'b1;
         tick();
         if (exp_acc) in_valid = 1'b0;
         if (rst) begin
            rst = 1'b0;
            #1;
            n_tests++;
            if ({out_valid_a, out_u_a, out_zf_a, out_idx_a, out_last_a, in_ready_a} !== 16'h0001 ||
                {out_valid_b, out_u_b, out_zf_b, out_idx_b, out_last_b, in_ready_b} !== 16'h0001) begin
               n_fail++;
               $display("FAIL rst_mid got a=%h b=%h want 0001",
                        {out_valid_a, out_u_a, out_zf_a, out_idx_a, out_last_a, in_ready_a},
                        {out_valid_b, out_u_b, out_zf_b, out_idx_b, out_last_b, in_ready_b});
            end
            break;
         end
         n_tests++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            n_fail++;
            $display("FAIL rst_mid_stream cyc=%0d got a=%h b=%h want a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 49) == 0);
         in_zf     = 1'($urandom_range(0, 1));
         in_state  = {$urandom, $urandom, $urandom, $urandom};
         tick();
         n_tests++;
         if (obs_a !== exp_a || obs_b !== exp_b) begin
            n_fail++;
            $display("FAIL random cyc=%0d got a=%h b=%h want a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
         end
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream(SBOX_FWD, "lsb_fwd_stream");
      test_stream(SBOX_INV, "msb_inv_stream");
      test_backpressure();
      test_back_to_back();
      test_zf_toggle();
      test_flush();
      test_rst_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
